// File: rtl/aes_round_sequencer_if.sv
// Handshake/control bundle between the AES round sequencer (slave) and its controller/consumer (master).
// Latency: none, wires only. Backpressure: out_ready throttles DONE; dec/inv exist only with AES_SEQ_DECRYPT_EN.
interface aes_round_sequencer_if;
    logic       start;
    logic [1:0] key_len;
    logic       abort;
    logic       out_ready;
    logic [3:0] round;
    logic       state_en;
    logic       final_round;
    logic       out_valid;
    logic       busy;
`ifdef AES_SEQ_DECRYPT_EN
    logic       dec;
    logic       inv;
`endif

    modport master (
        output start, key_len, abort, out_ready,
`ifdef AES_SEQ_DECRYPT_EN
        output dec,
        input  inv,
`endif
        input  round, state_en, final_round, out_valid, busy
    );

    modport slave (
        input  start, key_len, abort, out_ready,
`ifdef AES_SEQ_DECRYPT_EN
        input  dec,
        output inv,
`endif
        output round, state_en, final_round, out_valid, busy
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// AES round-key index sequencer (IDLE/INIT/ROUND/DONE); AES_SEQ_DECRYPT_EN adds reverse-order decrypt.
// Latency: out_valid Nr+1 edges after the start-sampling edge (Nr+2 counting that edge), state_en high Nr+1 cycles.
// Backpressure: DONE holds out_valid and round until out_ready; start in DONE with out_ready chains back-to-back.
module aes_round_sequencer #(
    parameter int unsigned NR_128 = 10,
    parameter int unsigned NR_192 = 12,
    parameter int unsigned NR_256 = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    aes_round_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_INIT, S_ROUND, S_DONE} state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_round, w_round_nxt;
    logic [3:0] r_nr;
    logic [3:0] w_nr_sel;
    logic [3:0] w_first_round;
    logic       w_accept;
    logic       w_last;
    logic       w_dec;
    logic       w_dec_sel;

    always_comb begin
        case (bus.key_len)
            2'b01:   w_nr_sel = 4'(NR_192);
            2'b10:   w_nr_sel = 4'(NR_256);
            default: w_nr_sel = 4'(NR_128);
        endcase
    end

    assign w_accept = bus.start && !bus.abort &&
                      ((r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready));

`ifdef AES_SEQ_DECRYPT_EN
    logic r_dec;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_dec <= 1'b0;
        else if (w_accept) r_dec <= bus.dec;
    end
    assign w_dec     = r_dec;
    assign w_dec_sel = bus.dec;
    assign bus.inv   = r_dec;
`else
    assign w_dec     = 1'b0;
    assign w_dec_sel = 1'b0;
`endif

    // Decrypt walks the key schedule backwards, so INIT uses the last key.
    assign w_first_round = w_dec_sel ? w_nr_sel : 4'd0;
    assign w_last        = w_dec ? (r_round == 4'd0) : (r_round == r_nr);

    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        if (bus.abort) begin
            w_state_nxt = S_IDLE;
            w_round_nxt = 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = S_INIT;
                        w_round_nxt = w_first_round;
                    end
                end
                S_INIT: begin
                    w_state_nxt = S_ROUND;
                    w_round_nxt = w_dec ? (r_round - 4'd1) : (r_round + 4'd1);
                end
                S_ROUND: begin
                    if (w_last) w_state_nxt = S_DONE;
                    else        w_round_nxt = w_dec ? (r_round - 4'd1) : (r_round + 4'd1);
                end
                S_DONE: begin
                    if (w_accept) begin
                        w_state_nxt = S_INIT;
                        w_round_nxt = w_first_round;
                    end else if (bus.out_ready) begin
                        w_state_nxt = S_IDLE;
                        w_round_nxt = 4'd0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_round_nxt = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_round <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_nr <= 4'(NR_128);
        else if (w_accept) r_nr <= w_nr_sel;
    end

    assign bus.round       = r_round;
    assign bus.state_en    = (r_state == S_INIT) || (r_state == S_ROUND);
    assign bus.final_round = (r_state == S_ROUND) && w_last;
    assign bus.out_valid   = (r_state == S_DONE);
    assign bus.busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: sequences per key length, backpressure, abort/reset, ignored inputs.
module tb_aes_round_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    aes_round_sequencer_if bus ();

    aes_round_sequencer #(.NR_128(10), .NR_192(12), .NR_256(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Caller sets start (and out_ready when chaining from DONE) before calling, at a negedge.
    // Edge 1 is the edge that samples start; out_valid must first be seen after edge nr+2.
    // poke=1 pulses start during ROUND, poke=2 flips key_len mid-operation.
    task automatic run_op(input string tag, input logic [1:0] kl, input logic d,
                          input int nr, input int poke);
        int sen = 0;
        int fin = 0;
        int vld_edge = 0;
        int exp_round;
        bus.key_len = kl;
`ifdef AES_SEQ_DECRYPT_EN
        bus.dec = d;
`endif
        for (int e = 1; e <= 40 && vld_edge == 0; e++) begin
            @(negedge clk);
            bus.start     = 1'b0;
            bus.out_ready = 1'b0;
            if (poke == 1 && e == 4) bus.start = 1'b1;
            if (poke == 2 && e == 3) bus.key_len = kl ^ 2'b10;
            check({tag, "_busy"}, int'(bus.busy), 1);
            if (bus.out_valid) begin
                vld_edge = e;
            end else begin
                exp_round = d ? (nr - (e - 1)) : (e - 1);
                check({tag, "_round"}, int'(bus.round), exp_round);
                sen += int'(bus.state_en);
                fin += int'(bus.final_round);
                if (bus.final_round) check({tag, "_final_at"}, int'(bus.round), d ? 0 : nr);
            end
        end
        check({tag, "_valid_edge"}, vld_edge, nr + 2);
        check({tag, "_state_en_cycles"}, sen, nr + 1);
        check({tag, "_final_cycles"}, fin, 1);
        check({tag, "_done_round"}, int'(bus.round), d ? 0 : nr);
        check({tag, "_done_state_en"}, int'(bus.state_en), 0);
        bus.key_len = 2'b00;
    endtask

    task automatic release_done(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_idle_busy"}, int'(bus.busy), 0);
        check({tag, "_idle_round"}, int'(bus.round), 0);
        check({tag, "_idle_valid"}, int'(bus.out_valid), 0);
    endtask

    task automatic wait_round(input string tag, input int r);
        int n = 0;
        while (int'(bus.round) != r && n < 40) begin
            @(negedge clk);
            bus.start = 1'b0;
            n++;
        end
        check({tag, "_reached_round"}, int'(bus.round), r);
    endtask

    task automatic watch_no_valid(input string tag);
        int seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen += int'(bus.out_valid);
        end
        check({tag, "_no_valid"}, seen, 0);
        check({tag, "_still_idle"}, int'(bus.busy), 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.key_len   = 2'b00;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
`ifdef AES_SEQ_DECRYPT_EN
        bus.dec       = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_round", int'(bus.round), 0);
        check("rst_state_en", int'(bus.state_en), 0);
        check("rst_final", int'(bus.final_round), 0);
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // AES-128, then hold DONE under backpressure and chain AES-192 back-to-back.
        bus.start = 1'b1;
        run_op("k128", 2'b00, 1'b0, 10, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", int'(bus.out_valid), 1);
            check("hold_round", int'(bus.round), 10);
        end
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        run_op("b2b192", 2'b01, 1'b0, 12, 0);
        release_done("b2b192");

        bus.start = 1'b1;
        run_op("k256_startpoke", 2'b10, 1'b0, 14, 1);
        release_done("k256");

        bus.start = 1'b1;
        run_op("k11_klpoke", 2'b11, 1'b0, 10, 2);
        release_done("k11");

        // Abort at round 5.
        bus.start = 1'b1;
        wait_round("abort", 5);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_round", int'(bus.round), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_state_en", int'(bus.state_en), 0);
        watch_no_valid("abort");

        // Asynchronous reset at round 7.
        bus.start = 1'b1;
        bus.key_len = 2'b10;
        wait_round("reset", 7);
        rst_n = 1'b0;
        #1;
        check("reset_round", int'(bus.round), 0);
        check("reset_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.key_len = 2'b00;
        watch_no_valid("reset");

        // Abort and start together in IDLE.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("abort_start_busy", int'(bus.busy), 0);
        check("abort_start_round", int'(bus.round), 0);
        watch_no_valid("abort_start");

`ifdef AES_SEQ_DECRYPT_EN
        bus.start = 1'b1;
        run_op("dec192", 2'b01, 1'b1, 12, 0);
        check("dec192_inv", int'(bus.inv), 1);
        release_done("dec192");
        bus.dec = 1'b0;
        bus.start = 1'b1;
        run_op("enc_after_dec", 2'b00, 1'b0, 10, 0);
        check("enc_inv", int'(bus.inv), 0);
        release_done("enc_after_dec");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 SHALL have parameter NR_128, default 10, meaning the round count for key_len=00.
REQ-002 SHALL have parameter NR_192, default 12, meaning the round count for key_len=01.
REQ-003 SHALL have parameter NR_256, default 14, meaning the round count for key_len=10; all NR_* values are 1..15.
REQ-004 SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, request a new block operation.
REQ-007 SHALL have port key_len, input, 2, key size: 00=128, 01=192, 10=256, 11=reserved (treated as 128).
REQ-008 SHALL have port abort, input, 1, synchronous cancel of the current operation.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the completed block.
REQ-010 SHALL have port round, output, 4, current round-key index.
REQ-011 SHALL have port state_en, output, 1, datapath state register load enable.
REQ-012 SHALL have port final_round, output, 1, current round skips MixColumns.
REQ-013 SHALL have port out_valid, output, 1, completed block is available.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, INIT, ROUND and DONE; state and round are registered; state_en, final_round, out_valid and busy are decoded from state and round only (Moore).
REQ-016 SHALL accept start only in IDLE, or in DONE in the same cycle as out_ready; it SHALL ignore start in INIT and ROUND.
REQ-017 SHALL latch Nr from key_len on start acceptance; key_len changes after acceptance have no effect.
REQ-018 SHALL, in INIT: drive round=0 and state_en=1 for exactly one cycle (initial AddRoundKey), then go to ROUND with round=1.
REQ-019 SHALL, in ROUND: drive state_en=1 and increment round by 1 each cycle, with final_round=1 exactly when round==Nr, then go to DONE.
REQ-020 SHALL, in DONE: drive out_valid=1 and state_en=0, and hold round=Nr until out_ready=1.
REQ-021 SHALL, in DONE with out_ready=1: go to INIT if start=1 (back-to-back), otherwise go to IDLE with round=0.
REQ-022 SHALL assert out_valid Nr+2 clock edges after the edge that samples the accepted start (12 for AES-128, 14 for AES-192, 16 for AES-256).
REQ-023 SHALL assert state_en for exactly Nr+1 cycles per operation, and final_round for exactly 1 cycle per operation.
REQ-024 SHALL give abort priority over all other inputs: from any state, the next state is IDLE with round=0; abort with start in the same cycle SHALL NOT start an operation.
REQ-025 SHALL never let round exceed 15 or wrap; round is held when not in INIT or ROUND.

Reset
REQ-026 SHALL, on rst_n low, immediately force state=IDLE, round=0 and latched Nr=NR_128, so that state_en=0, final_round=0, out_valid=0 and busy=0.
REQ-027 SHALL treat reset mid-operation as a discarded block: no out_valid until a new start is accepted after reset release.

Configuration
REQ-028 SHALL, with macro AES_SEQ_DECRYPT_EN defined, add input dec (1 bit, latched on start) and output inv (1 bit, equal to the latched dec).
REQ-029 SHALL, for an accepted start with dec=1: drive round=Nr in INIT; in ROUND, count round down from Nr-1 to 0 with final_round=1 when round==0; hold round=0 in DONE. Latency SHALL equal the encrypt latency.
REQ-030 SHALL, without AES_SEQ_DECRYPT_EN: omit dec and inv and support encrypt order only.

Verification
REQ-031 SHALL cover: key_len=00 with a start pulse -> round sequence 0,1..10; final_round only at round 10; out_valid at edge 12; state_en high for 11 cycles.
REQ-032 SHALL cover: key_len=10 and key_len=11 -> 14 rounds with out_valid at edge 16, and 10 rounds with out_valid at edge 12, respectively.
REQ-033 SHALL cover: out_ready held low for 5 cycles in DONE -> out_valid and round=Nr stable; then out_ready=1 with start=1 -> INIT on the next cycle, with no IDLE cycle.
REQ-034 SHALL cover: abort at round 5, and rst_n low at round 7 -> both return to IDLE/round=0 with no out_valid; abort and start together in IDLE -> stays in IDLE.
REQ-035 SHALL cover: start pulsed during ROUND, and key_len changed mid-operation -> both ignored; the sequence is unchanged.
REQ-036 SHALL cover, with AES_SEQ_DECRYPT_EN: dec=1 and key_len=01 -> round sequence 12,11..0; final_round at round 0; inv=1; out_valid at edge 14.
